irq_rr_arbiter: RTL
===================

// Module: irq_rr_arbiter
// PURPOSE
//  Round-robin interrupt arbiter with claim/complete handshake between the peripheral IRQ lines and the core's CSR/trap unit.
//  Latches requests, picks one enabled pending line fairly, holds it stable for the core, and tracks it in-service until the handler completes.
//  Drives the cause word for mcause and the per-line finish pulse back to peripherals.
// PARAMETERS
//  N_IRQ         16  number of interrupt lines, 2..32
//  CAUSE_OFFSET  16  added to winner id to form mcause code field
// PORTS
//  clk_i       in   1             clock; all state updates on posedge
//  rst_i       in   1             reset, asynchronous, active-low
//  int_req_i   in   N_IRQ         peripheral request lines
//  mie_i       in   N_IRQ         per-line enable (from mie CSR)
//  irq_ack_i   in   1             core takes trap (1-cycle pulse); valid only while irq_o=1
//  irq_done_i  in   1             handler finished (mret); valid only in SERVICE
//  irq_o       out  1             interrupt request to core
//  irq_id_o    out  $clog2(N_IRQ) winning line index
//  mcause_o    out  32            {1'b1, 31'(CAUSE_OFFSET + irq_id_o)}
//  int_fin_o   out  N_IRQ         one-hot 1-cycle pulse on completion
//  busy_o      out  1             state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, pending=0, rr_ptr=0, irq_o=0, irq_id_o=0, int_fin_o=0, busy_o=0; mcause_o reflects id 0.
//  - eligible = pending & mie_i; winner = first set bit at or above rr_ptr, wrapping from N_IRQ-1 to 0.
//  - FSM IDLE: eligible!=0 -> REQ, latch winner into irq_id_o (1-cycle latency req->irq_o).
//  - REQ: irq_o=1; irq_id_o/mcause_o frozen. irq_ack_i=1 -> SERVICE.
//    No ack and eligible[id]==0 (masked/withdrawn) -> IDLE, irq_o=0 next cycle. Ack wins over same-cycle withdrawal.
//  - SERVICE: irq_o=0; no further arbitration (no nesting). irq_done_i=1 -> IDLE,
//    int_fin_o[id]=1 for exactly that cycle after the transition edge, rr_ptr=(id+1) mod N_IRQ.
//  - irq_ack_i outside REQ and irq_done_i outside SERVICE are ignored.
//  - New arbitration earliest the cycle after returning to IDLE; done and new requests in the same cycle -> fin pulse and IDLE, then REQ next cycle.
//  - rr_ptr changes only on completion; a withdrawn REQ does not advance it.
//  - Reset asserted mid-REQ/SERVICE: immediate return to reset values, no int_fin_o pulse.
// CONFIGURATION
//  IRQ_ARB_EDGE_EN defined: pending[i] set on a 0->1 transition of int_req_i[i] (registered prev sample), set regardless of mie_i.
//    pending[i] is cleared on ack of line i. A set and clear in the same cycle on the same line leaves it set.
//  IRQ_ARB_EDGE_EN undefined: level mode. pending = int_req_i combinationally, with no storage.
//    The peripheral must hold the request until it sees int_fin_o.
// STRUCTURE
//  Package irq_arb_pkg: state_t enum {IDLE, REQ, SERVICE}, MCAUSE_INT_BIT = 32'h8000_0000, function rr_pick(eligible, ptr).
//  Sub-module irq_rr_picker: combinational masked rotate + priority encode.
//    Outputs: valid and idx from eligible and rr_ptr.
//  Top holds the FSM, the pending/edge registers, rr_ptr and the output registers.
// TESTING (N_IRQ=16, CAUSE_OFFSET=16)
//  1. Reset, then int_req_i=16'h0008, mie_i=16'hFFFF.
//     -> irq_o=1 next cycle, irq_id_o=3, mcause_o=32'h8000_0013.
//  2. Same, then ack, then done after 5 cycles.
//     -> int_fin_o=16'h0008 for 1 cycle, busy_o=0, rr_ptr=4.
//  3. int_req_i=16'h8011 held; three ack/done rounds.
//     -> ids served in order 0, 4, 15, then 0 again (wrap).
//  4. In REQ for id 2, clear mie_i[2] with no ack.
//     -> irq_o=0 next cycle, state IDLE, no int_fin_o pulse.
//  5. In REQ, assert ack and rst_i=0 in the same cycle.
//     -> all outputs at reset values, no SERVICE, no pulse.
//  6. IRQ_ARB_EDGE_EN: 1-cycle pulse on line 5 while mie_i[5]=0, then set mie_i[5]=1.
//     -> REQ id 5. In level build the same stimulus gives no request.

Source files
------------

// File: rtl/irq_arb_pkg.sv
// -----------------------------------------------------------------------------
// irq_arb_pkg
// Shared types and helpers for the round-robin interrupt arbiter.
//   state_t        : arbiter FSM states (IDLE, REQ, SERVICE)
//   MCAUSE_INT_BIT : interrupt flag bit of the mcause word
//   rr_pick()      : round-robin search over up to 32 lines; returns
//                    {valid, idx[4:0]} for the first eligible line at or
//                    above ptr, wrapping from n-1 back to 0
// -----------------------------------------------------------------------------
package irq_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [31:0] MCAUSE_INT_BIT = 32'h8000_0000;

    // Walks the lines starting at ptr. ptr < n and the offset < n, so a
    // single conditional subtraction performs the wrap-around modulo n.
    function automatic logic [5:0] rr_pick(input logic [31:0] eligible,
                                           input logic [4:0]  ptr,
                                           input logic [5:0]  n);
        logic       found;
        logic [4:0] idx;
        logic [5:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < 32; i++) begin
            cand = {1'b0, ptr} + 6'(i);
            if (cand >= n) begin
                cand = cand - n;
            end
            if (!found && (6'(i) < n) && eligible[cand[4:0]]) begin
                found = 1'b1;
                idx   = cand[4:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/irq_rr_picker.sv
// -----------------------------------------------------------------------------
// irq_rr_picker
// Combinational round-robin selector: masked rotate from ptr_i followed by a
// priority encode, yielding the first eligible line at or above ptr_i.
// Ports:
//   eligible_i [N_IRQ] : lines that are both pending and enabled
//   ptr_i      [IDW]   : round-robin start position
//   valid_o            : at least one eligible line exists
//   idx_o      [IDW]   : index of the selected line (0 when !valid_o)
// -----------------------------------------------------------------------------
module irq_rr_picker
    import irq_arb_pkg::*;
#(
    parameter  int N_IRQ = 16,
    localparam int IDW   = $clog2(N_IRQ)
) (
    input  logic [N_IRQ-1:0] eligible_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic             valid_o,
    output logic [IDW-1:0]   idx_o
);

    logic [5:0] pick;

    assign pick    = rr_pick(32'(eligible_i), 5'(ptr_i), 6'(N_IRQ));
    assign valid_o = pick[5];
    assign idx_o   = IDW'(pick[4:0]);

endmodule

// File: rtl/irq_rr_arbiter.sv
// -----------------------------------------------------------------------------
// irq_rr_arbiter
// Round-robin interrupt arbiter with claim/complete handshake to the core.
// Picks one enabled pending line fairly, holds it stable while requesting,
// tracks it in service until the handler completes, then pulses the line's
// finish bit and advances the round-robin pointer past the served line.
// Ports:
//   clk_i, rst_i (async, active-low)
//   int_req_i [N_IRQ]  peripheral request lines
//   mie_i     [N_IRQ]  per-line enable
//   irq_ack_i          core takes the trap (honoured only in REQ)
//   irq_done_i         handler finished (honoured only in SERVICE)
//   irq_o              interrupt request to the core
//   irq_id_o  [IDW]    winning line index
//   mcause_o  [32]     {1, CAUSE_OFFSET + irq_id_o}
//   int_fin_o [N_IRQ]  one-hot completion pulse
//   busy_o             FSM not idle
// Build option: define IRQ_ARB_EDGE_EN for edge-triggered pending latches;
// otherwise requests are level-sensitive and held by the peripheral.
// -----------------------------------------------------------------------------
module irq_rr_arbiter
    import irq_arb_pkg::*;
#(
    parameter  int N_IRQ        = 16,
    parameter  int CAUSE_OFFSET = 16,
    localparam int IDW          = $clog2(N_IRQ)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_IRQ-1:0] int_req_i,
    input  logic [N_IRQ-1:0] mie_i,
    input  logic             irq_ack_i,
    input  logic             irq_done_i,
    output logic             irq_o,
    output logic [IDW-1:0]   irq_id_o,
    output logic [31:0]      mcause_o,
    output logic [N_IRQ-1:0] int_fin_o,
    output logic             busy_o
);

    state_t             state_q;
    logic               irq_q;
    logic [IDW-1:0]     id_q;
    logic [N_IRQ-1:0]   fin_q;
    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     ptr_d;
    logic [N_IRQ-1:0]   pending;
    logic [N_IRQ-1:0]   eligible;
    logic [N_IRQ-1:0]   lineMask;
    logic               pickValid;
    logic [IDW-1:0]     pickIdx;

    assign lineMask = N_IRQ'(1) << id_q;

`ifdef IRQ_ARB_EDGE_EN
    logic [N_IRQ-1:0] pending_q;
    logic [N_IRQ-1:0] pending_d;
    logic [N_IRQ-1:0] reqPrev_q;
    logic [N_IRQ-1:0] pendSet;
    logic [N_IRQ-1:0] pendClr;

    // Rising edges set pending independent of mie; the ack of the granted
    // line clears it. Set is OR-ed last so a coincident new edge survives.
    assign pendSet   = int_req_i & ~reqPrev_q;
    assign pendClr   = (state_q == REQ && irq_ack_i) ? lineMask : '0;
    assign pending_d = (pending_q & ~pendClr) | pendSet;
    assign pending   = pending_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pending_q <= '0;
            reqPrev_q <= '0;
        end else begin
            pending_q <= pending_d;
            reqPrev_q <= int_req_i;
        end
    end
`else
    assign pending = int_req_i;
`endif

    assign eligible = pending & mie_i;

    irq_rr_picker #(
        .N_IRQ (N_IRQ)
    ) u_picker (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .valid_o    (pickValid),
        .idx_o      (pickIdx)
    );

    // Pointer moves one past the completed line, wrapping at N_IRQ-1.
    assign ptr_d = (id_q == IDW'(N_IRQ - 1)) ? '0 : id_q + 1'b1;

    // Arbitration only happens from IDLE, so a completion always spends one
    // cycle in IDLE before the next request can be raised. Ack is tested
    // before withdrawal so it wins when both occur in the same cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
            id_q    <= '0;
            fin_q   <= '0;
            ptr_q   <= '0;
        end else begin
            fin_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pickValid) begin
                        state_q <= REQ;
                        irq_q   <= 1'b1;
                        id_q    <= pickIdx;
                    end
                end
                REQ: begin
                    if (irq_ack_i) begin
                        state_q <= SERVICE;
                        irq_q   <= 1'b0;
                    end else if (!eligible[id_q]) begin
                        state_q <= IDLE;
                        irq_q   <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (irq_done_i) begin
                        state_q <= IDLE;
                        fin_q   <= lineMask;
                        ptr_q   <= ptr_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    assign irq_o     = irq_q;
    assign irq_id_o  = id_q;
    assign int_fin_o = fin_q;
    assign busy_o    = (state_q != IDLE);
    assign mcause_o  = MCAUSE_INT_BIT | {1'b0, 31'(CAUSE_OFFSET + int'(id_q))};

endmodule
